mul_div_unit: RTL and testbench

- Parametrised iterative radix-2 multiply/divide unit for the calculator datapath.
- Successor to the fixed multiplier that ran on a separate fast clock.
- Runs on the single module clock with a start/busy/done handshake.
- Supports signed and unsigned multiply and divide; results go to HI/LO registers read by the datapath.

---
 rtl/calc_pkg.sv | 16 +
 rtl/mdu_step.sv | 36 +++
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator multiply/divide unit.
package calc_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration, shared by multiply (shift-add) and divide
// (restoring shift-subtract). Operands are unsigned magnitudes.
//   multiply: acc = {partial product high, remaining multiplier bits}
//   divide:   acc = {partial remainder, dividend bits / quotient bits}
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out,
  output logic                 q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] part_rem;
  logic [WIDTH:0] diff;

  // Both step flavours are computed; div_mode selects which one is returned.
  // In divide mode the quotient bit slot (acc_out[0]) is left zero and the
  // caller merges q_bit into it.
  always_comb begin
    sum      = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    part_rem = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff     = part_rem - {1'b0, operand};
    q_bit    = 1'b0;
    acc_out  = acc_in;
    if (div_mode) begin
      q_bit   = ~diff[WIDTH];
      acc_out = {(q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0]), acc_in[WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply-divide unit with HI/LO result registers.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for start; operands sampled on accept
//   CALC    | WIDTH radix-2 steps on operand magnitudes
//   FIX     | sign correction, div-by-zero override, load hi/lo
//   DONE    | done pulse; start ignored
module mul_div_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               bzero_q, bzero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic               is_div, is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot, rem;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_q),
    .acc_in   (acc_q),
    .operand  (opnd_q),
    .acc_out  (step_acc),
    .q_bit    (step_q)
  );

  // Operand decode; the magnitude of MIN is MIN read as unsigned, which is exact.
  always_comb begin
    is_div    = (op == OP_DIVU) || (op == OP_DIV);
    is_signed = (op == OP_MUL)  || (op == OP_DIV);
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    prod_neg  = -acc_q;
    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the sequencer, datapath and result registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_raw_d  = a;
          div_d    = is_div;
          acc_d    = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          opnd_d   = is_div ? mag_b : mag_a;
          neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d = is_signed && a[WIDTH-1];
          bzero_d  = (b == '0);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!div_q) begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
          dz_d         = 1'b0;
        end else if (bzero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          lo_d = neg_lo_q ? -quot : quot;
          hi_d = neg_hi_q ? -rem : rem;
          dz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: vector table plus handshake
// and reset sequences.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam int LAT = 34;

  logic         clk0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks;
  int failures;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk0     (clk0),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic       dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Starts an operation at the next negedge and waits (bounded) for done.
  // lat counts rising edges with the start-sampling edge as edge 1; 0 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic busy_ok);
    bit got;
    @(negedge clk0);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0; got = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 100 && !got; n++) begin
      @(negedge clk0);
      start = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = ~o;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got = 1;
        lat = n;
      end
    end
  endtask

  initial begin
    int lat;
    logic bok;
    int dones;
    int first;

    checks = 0; failures = 0;
    vecs[0]  = '{"mulu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mul_m7x6",   2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{"mul_minmin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{"div_m7d2",   2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{"divu_100d7", 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[5]  = '{"div_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{"divu_zero",  2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{"mulu_3x4",   2'b00, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0};
    vecs[8]  = '{"div_zero_s", 2'b11, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{"div_7dm2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{"div_m7dm2",  2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[11] = '{"mul_7xm1",   2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[12] = '{"mulu_shift", 2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[13] = '{"divu_d1",    2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk0);
    check("reset_outputs", {28'd0, busy, done, div_zero, 1'b0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk0);

    // Vectors run back to back: each start lands in the first IDLE cycle after done.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      check({vecs[i].name, "_latency"}, lat, LAT);
      check({vecs[i].name, "_busy"}, {63'd0, bok}, 64'd1);
      check({vecs[i].name, "_hilo"}, {hi, lo}, {vecs[i].hi, vecs[i].lo});
      check({vecs[i].name, "_dz"}, {63'd0, div_zero}, {63'd0, vecs[i].dz});
    end

    // done is a single-cycle pulse and busy drops with it.
    @(negedge clk0);
    check("done_pulse_width", {62'd0, done, busy}, 64'd0);

    // start with new operands mid-CALC is ignored.
    @(negedge clk0);
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    dones = 0; first = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk0);
      start = (n == 5);
      if (n == 5) begin op = 2'b10; a = 32'd99; b = 32'd0; end
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    start = 1'b0;
    check("midcalc_done_count", dones, 1);
    check("midcalc_latency", first, LAT);
    check("midcalc_result_held", {hi, lo}, {32'd0, 32'd42});
    check("midcalc_dz", {63'd0, div_zero}, 64'd0);

    // Reset 10 edges into a signed divide.
    @(negedge clk0);
    start = 1'b1; op = 2'b11; a = 32'hFFFFFF9C; b = 32'd3;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk0);
      start = 1'b0;
    end
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("midop_reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    check("midop_reset_hilo", {hi, lo}, 64'd0);
    repeat (3) @(negedge clk0);
    reset = 1'b1;
    dones = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk0);
      if (done === 1'b1) dones++;
    end
    check("no_done_after_reset", dones, 0);
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    run_op(2'b00, 32'd5, 32'd5, lat, bok);
    check("post_reset_latency", lat, LAT);
    check("post_reset_mulu", {hi, lo}, {32'd0, 32'd25});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
